// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised synchronous FIFO.
//  - FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//  - fifo_clog2()         : address/count width helper that never returns 0,
//                           so a 1-bit pointer is still produced for DEPTH=2.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int fifo_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer side bundle of the FIFO.
//  master : the logic that writes/reads the FIFO (drives data_in, wr_en, rd_en,
//           af_thresh, ae_thresh, err_clr; observes everything else)
//  slave  : the FIFO itself
interface fifo_sync_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  import fifo_pkg::*;

  localparam int CNT_W = fifo_clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic [CNT_W-1:0]  af_thresh;
  logic [CNT_W-1:0]  ae_thresh;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              almostfull;
  logic              almostempty;
  logic [CNT_W-1:0]  count;
  logic              ovf_sticky;
  logic              udf_sticky;

  modport master (
    output data_in, wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    input  data_out, valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, ovf_sticky, udf_sticky
  );

  modport slave (
    input  data_in, wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    output data_out, valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, ovf_sticky, udf_sticky
  );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage array.
//  clk     : write clock
//  wr_en   : write strobe (already qualified by !full in the parent)
//  wr_addr : write address, wr_data : write data
//  rd_addr : read address, rd_data : asynchronous read data
module fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the empty flag gates every read, so stale
  // contents are never observed, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO, any DEPTH >= 2, standard or FWFT read.
//  clk, rst_n : clock (rising edge) and asynchronous active-low reset
//  bus        : fifo_sync_param_if.slave -- write/read requests, thresholds,
//               err_clr in; data_out/valid, per-cycle status pulses
//               (wr_ack/overflow/underflow), occupancy flags, count and
//               sticky error flags out.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int FWFT   = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_sync_param_if.slave  bus
);

  localparam int CNT_W = fifo_clog2(DEPTH + 1);
  localparam int PTR_W = fifo_clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty;
  logic              wr_acc, wr_rej, rd_acc, rd_rej;
  logic              wr_ack_q, overflow_q, underflow_q;
  logic              ovf_sticky_q, udf_sticky_q;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Acceptance uses pre-edge flags only: a read in the same cycle does not
  // make room for a write into a full FIFO.
  assign wr_acc = bus.wr_en & ~full;
  assign wr_rej = bus.wr_en &  full;
  assign rd_acc = bus.rd_en & ~empty;
  assign rd_rej = bus.rd_en &  empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Status pulses and sticky flags; a new event wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ack_q     <= wr_acc;
      overflow_q   <= wr_rej;
      underflow_q  <= rd_rej;
      ovf_sticky_q <= wr_rej | (ovf_sticky_q & ~bus.err_clr);
      udf_sticky_q <= rd_rej | (udf_sticky_q & ~bus.err_clr);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word is always presented; rd_en only acknowledges it.
      assign bus.data_out = rd_data;
      assign bus.valid    = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] data_out_q;
      logic              valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_q <= '0;
          valid_q    <= 1'b0;
        end else begin
          if (rd_acc) data_out_q <= rd_data;
          valid_q <= rd_acc;
        end
      end

      assign bus.data_out = data_out_q;
      assign bus.valid    = valid_q;
    end
  endgenerate

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count >= bus.af_thresh);
  assign bus.almostempty = (count <= bus.ae_thresh);
  assign bus.count       = count;
  assign bus.ovf_sticky  = ovf_sticky_q;
  assign bus.udf_sticky  = udf_sticky_q;

endmodule
